// File: rtl/eth_tx_framer_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet TX framer.
package eth_tx_framer_pkg;

    localparam int unsigned BYTE_LEN          = 8;
    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam int unsigned ETH_PREAMBLE_LEN  = 7;
    localparam logic [31:0] CRC32_POLY_REFL   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
    // Register value left after running the CRC over data followed by its own FCS.
    localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB20E3;
    localparam int unsigned ETH_MIN_FRAME_LEN = 60;
    localparam int unsigned ETH_MAX_FRAME_LEN = 1514;

    // Wide enough for ETH_MAX_FRAME_LEN; the length counter saturates rather than wraps.
    localparam int unsigned LEN_W  = 11;
    // Shared preamble / FCS / IFG step counter; bounds IFG_BYTES to 256.
    localparam int unsigned STEP_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StPad,
        StFcs,
        StIfg
    } tx_state_e;

    // FCS goes out as the complemented CRC, least significant byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] inv;
        inv = ~crc;
        return inv[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/eth_tx_framer_crc32_byte.sv
// One byte step of the reflected Ethernet CRC-32. Purely combinational so the
// same block can be reused by an RX FCS checker.
module eth_tx_framer_crc32_byte
    import eth_tx_framer_pkg::*;
(
    input  logic [31:0]         crc_i,
    input  logic [BYTE_LEN-1:0] data_i,
    output logic [31:0]         crc_o
);

    // Shift the byte in LSB first, folding in the reflected polynomial per bit.
    always_comb begin
        logic [31:0] c;
        c = crc_i;
        for (int i = 0; i < BYTE_LEN; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, upstream data, zero pad, FCS and
// inter-frame gap, one byte every BYTE_PERIOD clocks toward bytes_to_dibits.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int unsigned BYTE_PERIOD   = 4,
    parameter int unsigned MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
    parameter int unsigned MAX_FRAME_LEN = ETH_MAX_FRAME_LEN,
    parameter int unsigned IFG_BYTES     = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [BYTE_LEN-1:0] in_data_i,
    input  logic                in_valid_i,
    input  logic                in_last_i,
    output logic                in_ready_o,
    output logic [BYTE_LEN-1:0] out_byte_o,
    output logic                out_clk_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int unsigned TickW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;

    localparam logic [TickW-1:0]  TickLast = TickW'(BYTE_PERIOD - 1);
    localparam logic [LEN_W-1:0]  MinLen   = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0]  MaxLen   = LEN_W'(MAX_FRAME_LEN);
    localparam logic [STEP_W-1:0] PreLen   = STEP_W'(ETH_PREAMBLE_LEN);
    localparam logic [STEP_W-1:0] FcsLast  = STEP_W'(3);
    localparam logic [STEP_W-1:0] IfgLast  = STEP_W'(IFG_BYTES - 1);

    tx_state_e           state_q, state_d;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [31:0]         crc_q, crc_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                drop_q, drop_d;
    logic [BYTE_LEN-1:0] out_byte_q, out_byte_d;
    logic                out_clk_q, out_clk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                tick;
    logic [LEN_W-1:0]    len_inc;
    logic [BYTE_LEN-1:0] crc_data;
    logic [31:0]         crc_next;

    assign tick    = (tick_cnt_q == '0);
    assign len_inc = len_q + 1'b1;
    // Pad bytes are zeros but still covered by the FCS.
    assign crc_data = (state_q == StPad) ? '0 : in_data_i;

    eth_tx_framer_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (crc_data),
        .crc_o  (crc_next)
    );

    // Next-state, byte emission and upstream handshake.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
        len_d      = len_q;
        crc_d      = crc_q;
        step_d     = step_q;
        drop_d     = drop_q;
        out_byte_d = out_byte_q;
        out_clk_d  = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        in_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Accepting a frame does not consume the first byte.
                if (in_valid_i) begin
                    state_d    = StPreamble;
                    tick_cnt_d = '0;
                    busy_d     = 1'b1;
                    crc_d      = CRC32_INIT;
                    len_d      = '0;
                    step_d     = '0;
                    drop_d     = 1'b0;
                end
            end
            StPreamble: begin
                if (tick) begin
                    out_clk_d = 1'b1;
                    if (step_q == PreLen) begin
                        out_byte_d = ETH_SFD_BYTE;
                        step_d     = '0;
                        state_d    = StData;
                    end else begin
                        out_byte_d = ETH_PREAMBLE_BYTE;
                        step_d     = step_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (drop_q) begin
                    // Over-length tail: swallow bytes at full rate until in_last.
                    in_ready_o = 1'b1;
                    if (in_valid_i && in_last_i) begin
                        drop_d  = 1'b0;
                        step_d  = '0;
                        state_d = StFcs;
                    end
                end else if (tick) begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        out_clk_d  = 1'b1;
                        out_byte_d = in_data_i;
                        crc_d      = crc_next;
                        len_d      = len_inc;
                        if (in_last_i) begin
                            step_d  = '0;
                            state_d = (len_inc < MinLen) ? StPad : StFcs;
                        end else if (len_inc == MaxLen) begin
                            err_d  = 1'b1;
                            drop_d = 1'b1;
                        end
                    end else begin
                        // Underrun: the frame is cut short on the wire, no FCS.
                        err_d   = 1'b1;
                        step_d  = '0;
                        state_d = StIfg;
                    end
                end
            end
            StPad: begin
                if (tick) begin
                    out_clk_d  = 1'b1;
                    out_byte_d = '0;
                    crc_d      = crc_next;
                    len_d      = len_inc;
                    if (len_inc == MinLen) begin
                        step_d  = '0;
                        state_d = StFcs;
                    end
                end
            end
            StFcs: begin
                if (tick) begin
                    out_clk_d  = 1'b1;
                    out_byte_d = fcs_byte(crc_q, step_q[1:0]);
                    if (step_q == FcsLast) begin
                        done_d  = 1'b1;
                        step_d  = '0;
                        state_d = StIfg;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StIfg: begin
                if (tick) begin
                    if (step_q == IfgLast) begin
                        busy_d  = 1'b0;
                        step_d  = '0;
                        state_d = StIdle;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset drops everything immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            len_q      <= '0;
            crc_q      <= CRC32_INIT;
            step_q     <= '0;
            drop_q     <= 1'b0;
            out_byte_q <= '0;
            out_clk_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            step_q     <= step_d;
            drop_q     <= drop_d;
            out_byte_q <= out_byte_d;
            out_clk_q  <= out_clk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign out_byte_o = out_byte_q;
    assign out_clk_o  = out_clk_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: random frames against a reference
// model that builds the expected wire image from the framing rules directly.
module tb_eth_tx_framer;

    localparam int MINL = 60;
    localparam int MAXL = 1514;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_last_i;
    logic       in_ready_o;
    logic [7:0] out_byte_o;
    logic       out_clk_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    always #5 clk_i = ~clk_i;

    eth_tx_framer dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_last_i  (in_last_i),
        .in_ready_o (in_ready_o),
        .out_byte_o (out_byte_o),
        .out_clk_o  (out_clk_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Wire-side monitor.
    int         cyc = 0;
    logic [7:0] cap_q[$];
    int         cap_t[$];
    int         done_tq[$];
    int         fall_tq[$];
    int         rise_tq[$];
    int         err_cnt = 0;
    logic       busy_prev = 1'b0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk_i) begin
        cyc++;
        if (out_clk_o) begin
            cap_q.push_back(out_byte_o);
            cap_t.push_back(cyc);
        end
        if (done_o) done_tq.push_back(cyc);
        if (err_o) err_cnt++;
        if (busy_prev && !busy_o) fall_tq.push_back(cyc);
        if (!busy_prev && busy_o) rise_tq.push_back(cyc);
        busy_prev = busy_o;
    end

    task automatic clear_mon();
        @(posedge clk_i);
        cap_q.delete();
        cap_t.delete();
        done_tq.delete();
        fall_tq.delete();
        rise_tq.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    // Reference CRC: MSB-first normal polynomial on bit-reversed bytes.
    function automatic logic [31:0] refl32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    function automatic logic [31:0] crc_msb(input logic [31:0] c, input logic [7:0] d);
        logic [7:0] rd;
        for (int i = 0; i < 8; i++) rd[i] = d[7-i];
        c = c ^ {rd, 24'h0};
        for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        return c;
    endfunction

    // Append the expected wire image of tx_q to exp_q; stop_after >= 0 models underrun.
    task automatic build_expected(input int stop_after);
        logic [7:0]  body[$];
        logic [31:0] c;
        logic [31:0] fcs;
        int          n;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        if (stop_after >= 0) begin
            for (int i = 0; i < stop_after; i++) exp_q.push_back(tx_q[i]);
            return;
        end
        n = (tx_q.size() > MAXL) ? MAXL : tx_q.size();
        for (int i = 0; i < n; i++) body.push_back(tx_q[i]);
        while (body.size() < MINL) body.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc_msb(c, body[i]);
        fcs = ~refl32(c);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    endtask

    // Present tx_q upstream, honouring in_ready; stop_after >= 0 withholds the rest.
    task automatic drive_frame(input int stop_after, output int consumed);
        int   idx = 0;
        int   budget = 0;
        int   lim;
        logic take;
        lim = (stop_after >= 0) ? stop_after : tx_q.size();
        @(negedge clk_i);
        while (idx < lim && budget < 20000) begin
            in_valid_i = 1'b1;
            in_data_i  = tx_q[idx];
            in_last_i  = (idx == tx_q.size() - 1);
            take       = in_ready_o;
            @(negedge clk_i);
            if (take) idx++;
            budget++;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = 8'h00;
        consumed   = idx;
        n_cmp++;
        if (idx != lim) begin
            n_bad++;
            $display("FAIL drive_consumed: got %0d bytes taken, need %0d", idx, lim);
        end
    endtask

    task automatic wait_idle(input string tag);
        int budget = 0;
        while (busy_o && budget < 2000) begin
            @(negedge clk_i);
            budget++;
        end
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_timeout: busy got %b need 0", tag, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        in_valid_i = 1'b1;
        in_last_i  = 1'b0;
        in_data_i  = 8'hA5;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (out_byte_o !== 8'h00) begin
            n_bad++; $display("FAIL reset_out_byte: got %h need 00", out_byte_o);
        end
        n_cmp++;
        if ({out_clk_o, busy_o, done_o, err_o} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got clk/busy/done/err %b%b%b%b need 0000",
                     out_clk_o, busy_o, done_o, err_o);
        end
        n_cmp++;
        if (in_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %b need 0", in_ready_o);
        end
        in_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_accept: busy got %b need 0", busy_o);
        end
    endtask

    task automatic test_min_frame(input string tag);
        int consumed;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 60; i++) tx_q.push_back(8'(i));
        build_expected(-1);
        drive_frame(-1, consumed);
        wait_idle(tag);
        n_cmp++;
        if (cap_q.size() != 72) begin
            n_bad++; $display("FAIL %s_count: got %0d bytes need 72", tag, cap_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL %s_byte[%0d]: got %h need %h", tag, i, cap_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < cap_t.size(); i++) begin
            n_cmp++;
            if (cap_t[i] - cap_t[i-1] != 4) begin
                n_bad++;
                $display("FAIL %s_spacing[%0d]: got %0d cycles need 4", tag, i, cap_t[i] - cap_t[i-1]);
            end
        end
        n_cmp++;
        if (rise_tq.size() != 1 || cap_t.size() == 0 || cap_t[0] - rise_tq[0] != 1) begin
            n_bad++; $display("FAIL %s_first_outclk: not 1 cycle after busy rise", tag);
        end
        n_cmp++;
        if (done_tq.size() != 1 || cap_t.size() != 72 || done_tq[0] != cap_t[71]) begin
            n_bad++; $display("FAIL %s_done: got %0d pulses, need 1 on byte 72", tag, done_tq.size());
        end
        n_cmp++;
        if (fall_tq.size() != 1 || done_tq.size() != 1 || fall_tq[0] - done_tq[0] != 48) begin
            n_bad++; $display("FAIL %s_ifg: busy fall not 48 cycles after done", tag);
        end
        n_cmp++;
        if (err_cnt != 0) begin
            n_bad++; $display("FAIL %s_err: got %0d pulses need 0", tag, err_cnt);
        end
    endtask

    task automatic test_pad();
        int          consumed;
        logic [31:0] c;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 14; i++) tx_q.push_back(8'($urandom));
        build_expected(-1);
        drive_frame(-1, consumed);
        wait_idle("pad");
        n_cmp++;
        if (cap_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL pad_count: got %0d bytes need %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL pad_byte[%0d]: got %h need %h", i, cap_q[i], exp_q[i]);
            end
        end
        c = 32'hFFFFFFFF;
        for (int i = 8; i < cap_q.size(); i++) c = crc_msb(c, cap_q[i]);
        n_cmp++;
        if (refl32(c) !== 32'hDEBB20E3) begin
            n_bad++; $display("FAIL pad_residue: got %h need debb20e3", refl32(c));
        end
    endtask

    task automatic test_random_frames();
        int consumed;
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            tx_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 100)); i++) tx_q.push_back(8'($urandom));
            build_expected(-1);
            drive_frame(-1, consumed);
            wait_idle("rand");
            n_cmp++;
            if (cap_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d bytes need %0d", f, cap_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                n_cmp++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_byte[%0d]: got %h need %h", f, i, cap_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if (done_tq.size() != 1 || err_cnt != 0) begin
                n_bad++;
                $display("FAIL rand%0d_flags: got done %0d err %0d need 1 0", f, done_tq.size(), err_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        int consumed;
        clear_mon();
        for (int f = 0; f < 2; f++) begin
            tx_q.delete();
            for (int i = 0; i < 60; i++) tx_q.push_back(8'($urandom));
            build_expected(-1);
            drive_frame(-1, consumed);
        end
        wait_idle("b2b");
        n_cmp++;
        if (cap_q.size() != 144) begin
            n_bad++; $display("FAIL b2b_count: got %0d bytes need 144", cap_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL b2b_byte[%0d]: got %h need %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (done_tq.size() != 2 || fall_tq.size() != 2 || rise_tq.size() != 2 ||
            cap_t.size() != 144) begin
            n_bad++;
            $display("FAIL b2b_events: got done %0d falls %0d rises %0d need 2 2 2",
                     done_tq.size(), fall_tq.size(), rise_tq.size());
        end else begin
            n_cmp++;
            if (fall_tq[0] - done_tq[0] != 48 || rise_tq[1] - fall_tq[0] != 1 ||
                cap_t[72] - fall_tq[0] != 2) begin
                n_bad++;
                $display("FAIL b2b_gap: got ifg %0d low %0d restart %0d need 48 1 2",
                         fall_tq[0] - done_tq[0], rise_tq[1] - fall_tq[0], cap_t[72] - fall_tq[0]);
            end
        end
    endtask

    task automatic test_underrun();
        int consumed;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 40; i++) tx_q.push_back(8'($urandom));
        build_expected(20);
        drive_frame(20, consumed);
        wait_idle("underrun");
        n_cmp++;
        if (cap_q.size() != 28) begin
            n_bad++; $display("FAIL underrun_count: got %0d bytes need 28", cap_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL underrun_byte[%0d]: got %h need %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (err_cnt != 1) begin
            n_bad++; $display("FAIL underrun_err: got %0d cycles need 1", err_cnt);
        end
        n_cmp++;
        if (done_tq.size() != 0) begin
            n_bad++; $display("FAIL underrun_done: got %0d pulses need 0", done_tq.size());
        end
        n_cmp++;
        if (in_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL underrun_idle_ready: got %b need 0", in_ready_o);
        end
    endtask

    task automatic test_overlength();
        int consumed;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 1600; i++) tx_q.push_back(8'($urandom));
        build_expected(-1);
        drive_frame(-1, consumed);
        wait_idle("overlen");
        n_cmp++;
        if (cap_q.size() != 8 + MAXL + 4) begin
            n_bad++; $display("FAIL overlen_count: got %0d bytes need %0d", cap_q.size(), 8 + MAXL + 4);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL overlen_byte[%0d]: got %h need %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (err_cnt != 1) begin
            n_bad++; $display("FAIL overlen_err: got %0d cycles need 1", err_cnt);
        end
        n_cmp++;
        if (done_tq.size() != 1) begin
            n_bad++; $display("FAIL overlen_done: got %0d pulses need 1", done_tq.size());
        end
        n_cmp++;
        if (consumed != 1600) begin
            n_bad++; $display("FAIL overlen_consumed: got %0d need 1600", consumed);
        end
    endtask

    task automatic test_reset_midframe();
        int consumed;
        int budget = 0;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 60; i++) tx_q.push_back(8'(i));
        drive_frame(-1, consumed);
        while (cap_q.size() < 70 && budget < 500) begin
            @(negedge clk_i);
            #1;
            budget++;
        end
        n_cmp++;
        if (cap_q.size() != 70) begin
            n_bad++; $display("FAIL midreset_reach: got %0d bytes need 70", cap_q.size());
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({out_byte_o, out_clk_o, busy_o, done_o, err_o, in_ready_o} !== 13'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got byte %h clk %b busy %b done %b err %b rdy %b need 0",
                     out_byte_o, out_clk_o, busy_o, done_o, err_o, in_ready_o);
        end
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (done_tq.size() != 0 || cap_q.size() != 70) begin
            n_bad++;
            $display("FAIL midreset_quiet: got done %0d bytes %0d need 0 70", done_tq.size(), cap_q.size());
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        test_min_frame("after_reset");
    endtask

    initial begin
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = 8'h00;
        test_reset();
        test_min_frame("min");
        test_pad();
        test_random_frames();
        test_back_to_back();
        test_underrun();
        test_overlength();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
